// File: rtl/instr_fetch_unit.sv
// PC and fetch stage: drives imem with the word address and registers the
// returned word into a valid/ready slot for decode.
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 6,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] BUBBLE   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus1,
    output logic [1:0]        fetch_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              vld_q;
    logic              vld_d;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0] idpc_q;
    logic [ADDR_W-1:0] idpc_d;

    logic slot_free;
    logic do_halt;
    logic do_redir;
    logic do_load;

    assign slot_free = !vld_q || id_ready;

    // Mutually exclusive actions for a RUN cycle, in priority order.
    assign do_halt  = halt;
    assign do_redir = !halt && redirect_valid;
    assign do_load  = !halt && !redirect_valid && slot_free;

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE lasts one clock, halt is sticky until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = halt ? S_HALT : S_RUN;
            S_RUN:   state_d = halt ? S_HALT : S_RUN;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of pc and the decode slot for the current state.
    always_comb begin
        pc_d    = pc_q;
        vld_d   = vld_q;
        instr_d = instr_q;
        idpc_d  = idpc_q;
        unique case (state_q)
            S_IDLE: begin
                if (do_redir) begin
                    pc_d = redirect_pc;
                end
            end
            S_RUN: begin
                unique case (1'b1)
                    do_halt: begin
                        vld_d   = 1'b0;
                        instr_d = BUBBLE;
                    end
                    do_redir: begin
                        pc_d    = redirect_pc;
                        vld_d   = 1'b0;
                        instr_d = BUBBLE;
                    end
                    do_load: begin
                        pc_d    = pc_q + 1'b1;
                        vld_d   = 1'b1;
                        instr_d = imem_rdata;
                        idpc_d  = pc_q;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // PC and decode slot registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            instr_q <= BUBBLE;
            idpc_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            idpc_q  <= idpc_d;
        end
    end

    // Outputs come straight from registers; only id_pc_plus1 is derived.
    always_comb begin
        fetch_state = state_q;
        imem_addr   = pc_q;
        id_valid    = vld_q;
        id_instr    = instr_q;
        id_pc       = idpc_q;
        id_pc_plus1 = idpc_q + 1'b1;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural imem, scoreboard of expected
// fetches popped on every decode handshake, plus direct state checks.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic        halt;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [5:0]  id_pc;
    logic [5:0]  id_pc_plus1;
    logic [1:0]  fetch_state;

    logic [31:0] mem [64];

    typedef struct packed {
        logic [5:0]  pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus1    (id_pc_plus1),
        .fetch_state    (fetch_state)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = mem[a];
        sb.push_back(e);
    endtask

    // Every accepted instruction must match the oldest expected fetch.
    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] p1;
        if (rst_n && id_valid && id_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e  = sb.pop_front();
                p1 = e.pc + 6'd1;
                chk("sb_pc", {26'd0, id_pc}, {26'd0, e.pc});
                chk("sb_instr", id_instr, e.instr);
                chk("sb_pc1", {26'd0, id_pc_plus1}, {26'd0, p1});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'd11;
        mem[1] = 32'd22;
        mem[2] = 32'd33;
        mem[3] = 32'd44;

        rst_n          = 1'b0;
        id_ready       = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) tick();

        chk("rst_vld", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_pc", {26'd0, id_pc}, 32'd0);
        chk("rst_state", {30'd0, fetch_state}, 32'd0);
        chk("rst_addr", {26'd0, imem_addr}, 32'd0);

        // sequential fetch
        push(6'd0);
        push(6'd1);
        push(6'd2);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_state", {30'd0, fetch_state}, 32'd1);
        chk("idle_vld", {31'd0, id_valid}, 32'd0);
        chk("idle_addr", {26'd0, imem_addr}, 32'd0);
        tick();
        chk("t1_pc0", {26'd0, id_pc}, 32'd0);
        tick();
        tick();
        chk("t1_pc2", {26'd0, id_pc}, 32'd2);

        // stall
        id_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("st_instr", id_instr, 32'd33);
            chk("st_pc", {26'd0, id_pc}, 32'd2);
            chk("st_addr", {26'd0, imem_addr}, 32'd3);
            chk("st_vld", {31'd0, id_valid}, 32'd1);
        end
        push(6'd3);
        id_ready = 1'b1;
        tick();
        chk("t2_pc3", {26'd0, id_pc}, 32'd3);
        chk("t2_instr", id_instr, 32'd44);
        tick();
        chk("t2_pc4", {26'd0, id_pc}, 32'd4);

        // redirect while stalled
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 6'd40;
        tick();
        chk("t3_vld", {31'd0, id_valid}, 32'd0);
        chk("t3_addr", {26'd0, imem_addr}, 32'd40);
        chk("t3_bub", id_instr, 32'd0);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        push(6'd40);
        tick();
        chk("t3_pc", {26'd0, id_pc}, 32'd40);
        chk("t3_instr", id_instr, mem[40]);

        // wrap
        redirect_valid = 1'b1;
        redirect_pc    = 6'd62;
        for (int i = 0; i < 7; i++) push(6'(62 + i));
        tick();
        redirect_valid = 1'b0;
        chk("t4_bub", {31'd0, id_valid}, 32'd0);
        tick();
        tick();
        chk("t4_pc63", {26'd0, id_pc}, 32'd63);
        chk("t4_p1", {26'd0, id_pc_plus1}, 32'd0);
        repeat (5) tick();
        chk("t4_pc4", {26'd0, id_pc}, 32'd4);
        chk("t4_addr", {26'd0, imem_addr}, 32'd5);

        // halt beats redirect, then sticks
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 6'd20;
        tick();
        halt = 1'b0;
        chk("t5_state", {30'd0, fetch_state}, 32'd2);
        chk("t5_vld", {31'd0, id_valid}, 32'd0);
        chk("t5_addr", {26'd0, imem_addr}, 32'd5);
        chk("t5_bub", id_instr, 32'd0);
        for (int i = 0; i < 3; i++) begin
            redirect_pc = 6'(30 + i);
            tick();
            chk("t5_hstate", {30'd0, fetch_state}, 32'd2);
            chk("t5_haddr", {26'd0, imem_addr}, 32'd5);
            chk("t5_hvld", {31'd0, id_valid}, 32'd0);
        end
        redirect_valid = 1'b0;
        chk("t5_sb", sb.size(), 32'd0);

        // async reset mid-stall
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        push(6'd0);
        push(6'd1);
        repeat (4) tick();
        chk("t6_pc2", {26'd0, id_pc}, 32'd2);
        id_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_vld", {31'd0, id_valid}, 32'd0);
        chk("t6_state", {30'd0, fetch_state}, 32'd0);
        chk("t6_addr", {26'd0, imem_addr}, 32'd0);
        chk("t6_pc", {26'd0, id_pc}, 32'd0);
        chk("t6_instr", id_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(6'd0);
        tick();
        chk("t6_idle", {30'd0, fetch_state}, 32'd1);
        chk("t6_ivld", {31'd0, id_valid}, 32'd0);
        id_ready = 1'b1;
        tick();
        chk("t6_rpc", {26'd0, id_pc}, 32'd0);
        chk("t6_rvld", {31'd0, id_valid}, 32'd1);
        tick();
        chk("end_sb", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
